tia_horizontal_timing_generator: RTL



---
 rtl/tia_horizontal_timing_generator_if.sv | 32 +++
 rtl/tia_horizontal_timing_generator.sv | 80 ++++++++
 2 files changed

// File: rtl/tia_horizontal_timing_generator_if.sv
// tia_horizontal_timing_generator_if: CPU strobes, vertical levels and horizontal timing outputs
//   master drives wsyn/rsyn/hmove/vsyn/vblk and reads the timing outputs;
//   slave is the timing generator side.
interface tia_horizontal_timing_generator_if #(
    parameter int COUNT_WIDTH = 8
);
    logic                   wsyn;
    logic                   rsyn;
    logic                   hmove;
    logic                   vsyn;
    logic                   vblk;
    logic [COUNT_WIDTH-1:0] hcount;
    logic                   hsync;
    logic                   cb;
    logic                   hblank;
    logic                   late_hblank;
    logic                   blank;
    logic                   syn;
    logic                   rdy;
    logic                   motck;
    logic                   eol;

    modport master (
        output wsyn, rsyn, hmove, vsyn, vblk,
        input  hcount, hsync, cb, hblank, late_hblank, blank, syn, rdy, motck, eol
    );

    modport slave (
        input  wsyn, rsyn, hmove, vsyn, vblk,
        output hcount, hsync, cb, hblank, late_hblank, blank, syn, rdy, motck, eol
    );
endinterface

// File: rtl/tia_horizontal_timing_generator.sv
// tia_horizontal_timing_generator: binary-counter TIA horizontal timing with WSYNC stall, RSYNC, HMOVE blank and motion burst
//   clk : colour clock
//   r   : synchronous active-high reset
//   bus : slave side; strobes wsyn/rsyn/hmove, levels vsyn/vblk in;
//         hcount, hsync, cb, hblank, late_hblank, blank, syn, rdy, motck, eol out
module tia_horizontal_timing_generator #(
    parameter int CLOCKS_PER_LINE = 228,
    parameter int COUNT_WIDTH     = 8,
    parameter int HSYNC_START     = 20,
    parameter int HSYNC_END       = 36,
    parameter int CB_START        = 40,
    parameter int CB_END          = 56,
    parameter int HBLANK_END      = 68,
    parameter int HMOVE_EXTEND    = 8,
    parameter int MOTCK_PULSES    = 15,
    parameter int MOTCK_PERIOD    = 4
) (
    input logic                                  clk,
    input logic                                  r,
    tia_horizontal_timing_generator_if.slave     bus
);
    localparam int KW = $clog2(MOTCK_PULSES + 1);
    localparam int PW = $clog2(MOTCK_PERIOD);
    typedef enum logic {RUN, WAIT} state_t;
    state_t                 state_q;
    logic [COUNT_WIDTH-1:0] hcount_q, hcount_d;
    logic                   late_q, vblk_q, vsyn_q, busy_q, motck_q;
    logic [KW-1:0]          k_q;
    logic [PW-1:0]          ph_q;
    logic                   eol;
    assign eol = hcount_q == COUNT_WIDTH'(CLOCKS_PER_LINE - 1);
    always_comb hcount_d = (bus.rsyn || eol) ? '0 : hcount_q + 1'b1;
    always_ff @(posedge clk) begin
        if (r) begin
            state_q  <= RUN;
            hcount_q <= '0;
            late_q   <= 1'b0;
            vblk_q   <= 1'b0;
            vsyn_q   <= 1'b0;
            busy_q   <= 1'b0;
            motck_q  <= 1'b0;
            k_q      <= '0;
            ph_q     <= '0;
        end else begin
            hcount_q <= hcount_d;
            vblk_q   <= bus.vblk;
            vsyn_q   <= bus.vsyn;
            // Release on the edge that starts a new line wins over a new wsyn.
            state_q  <= (hcount_d == '0) ? RUN : (bus.wsyn ? WAIT : state_q);
            late_q   <= bus.hmove | (late_q & (hcount_d != COUNT_WIDTH'(HBLANK_END + HMOVE_EXTEND)));
            if (bus.hmove) begin
                busy_q  <= 1'b1;
                motck_q <= 1'b0;
                k_q     <= '0;
                ph_q    <= '0;
            end else if (busy_q) begin
                // Phase 0 of each period emits a pulse; the last pulse ends the burst.
                motck_q <= ph_q == '0;
                ph_q    <= (ph_q == PW'(MOTCK_PERIOD - 1)) ? '0 : ph_q + 1'b1;
                if (ph_q == '0) begin
                    k_q    <= k_q + 1'b1;
                    busy_q <= k_q != KW'(MOTCK_PULSES - 1);
                end
            end else begin
                motck_q <= 1'b0;
            end
        end
    end
    assign bus.hcount      = hcount_q;
    assign bus.hsync       = hcount_q >= COUNT_WIDTH'(HSYNC_START) && hcount_q < COUNT_WIDTH'(HSYNC_END);
    assign bus.cb          = hcount_q >= COUNT_WIDTH'(CB_START) && hcount_q < COUNT_WIDTH'(CB_END);
    assign bus.hblank      = hcount_q < COUNT_WIDTH'(HBLANK_END) ||
                             (late_q && hcount_q < COUNT_WIDTH'(HBLANK_END + HMOVE_EXTEND));
    assign bus.late_hblank = late_q;
    assign bus.blank       = bus.hblank | vblk_q;
    assign bus.syn         = bus.hsync | vsyn_q;
    assign bus.rdy         = state_q == RUN;
    assign bus.motck       = motck_q;
    assign bus.eol         = eol;
endmodule
